// File: rtl/br_flow_pkg.sv
// br_flow_pkg: shared arbitration-mode enum and round-robin index helper for flow blocks
package br_flow_pkg;
  typedef enum logic {
    BrFlowArbFixed      = 1'b0,
    BrFlowArbRoundRobin = 1'b1
  } br_flow_arb_mode_e;
  function automatic int unsigned br_flow_rr_next(input int unsigned idx, input int unsigned num);
    return (idx + 32'd1 >= num) ? 32'd0 : idx + 32'd1;
  endfunction
endpackage

// File: rtl/br_flow_reg_fwd.sv
// br_flow_reg_fwd: forward ready-valid pipeline register with full throughput and stable pop under backpressure
module br_flow_reg_fwd #(
  parameter int Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             push_ready,
  input  logic             push_valid,
  input  logic [Width-1:0] push_data,
  input  logic             pop_ready,
  output logic             pop_valid,
  output logic [Width-1:0] pop_data
);
  assign push_ready = !rst && (!pop_valid || pop_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_valid <= 1'b0;
      pop_data  <= '0;
    end else if (push_ready) begin
      pop_valid <= push_valid;
      if (push_valid) pop_data <= push_data;
    end
  end
endmodule

// File: rtl/br_flow_mux_select_reg.sv
// br_flow_mux_select_reg: N:1 ready-valid mux with fixed or round-robin arbitration and a registered pop side
module br_flow_mux_select_reg
  import br_flow_pkg::*;
#(
  parameter int NumFlows    = 2,
  parameter int DataWidth   = 1,
  parameter int ArbMode     = 0,
  parameter int FlowIdWidth = $clog2(NumFlows)
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic [NumFlows-1:0]                push_ready,
  input  logic [NumFlows-1:0]                push_valid,
  input  logic [NumFlows-1:0][DataWidth-1:0] push_data,
  input  logic                               pop_ready,
  output logic                               pop_valid,
  output logic [DataWidth-1:0]               pop_data,
  output logic [FlowIdWidth-1:0]             pop_flow_id
);
  localparam bit RoundRobin = (ArbMode == int'(BrFlowArbRoundRobin));
  if (NumFlows < 2 || DataWidth < 1 || ArbMode < 0 || ArbMode > 1 || FlowIdWidth != $clog2(NumFlows)) begin : g_bad_params
    $error("br_flow_mux_select_reg: illegal parameters");
  end
  logic [NumFlows-1:0]    grant;
  logic [FlowIdWidth-1:0] grant_idx;
  logic [FlowIdWidth-1:0] idx;
  logic [FlowIdWidth-1:0] last_grant;
  logic                   found;
  logic                   stage_ready;
  logic [NumFlows-1:0]    xfer;
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = RoundRobin ? FlowIdWidth'(br_flow_rr_next(32'(last_grant), NumFlows)) : '0;
    for (int k = 0; k < NumFlows; k++) begin
      if (!found && push_valid[idx]) begin
        found            = 1'b1;
        grant[idx]       = 1'b1;
        grant_idx        = idx;
      end
      idx = FlowIdWidth'(br_flow_rr_next(32'(idx), NumFlows));
    end
  end
  assign push_ready = stage_ready ? grant : '0;
  assign xfer       = push_valid & push_ready;
  always_ff @(posedge clk) begin
    if (rst) last_grant <= FlowIdWidth'(NumFlows - 1);
    else if (|xfer) last_grant <= grant_idx;
  end
  br_flow_reg_fwd #(
    .Width(DataWidth + FlowIdWidth)
  ) u_reg (
    .clk       (clk),
    .rst       (rst),
    .push_ready(stage_ready),
    .push_valid(found),
    .push_data ({grant_idx, push_data[grant_idx]}),
    .pop_ready (pop_ready),
    .pop_valid (pop_valid),
    .pop_data  ({pop_flow_id, pop_data})
  );
  a_xfer_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(xfer));
  a_pop_stable: assert property (@(posedge clk) disable iff (rst)
    pop_valid && !pop_ready |=> pop_valid && $stable(pop_data) && $stable(pop_flow_id));
  for (genvar i = 0; i < NumFlows; i++) begin : g_push_stable
    a_push_hold: assert property (@(posedge clk) disable iff (rst)
      push_valid[i] && !push_ready[i] |=> push_valid[i] && $stable(push_data[i]));
  end
  if (RoundRobin) begin : g_fair
    for (genvar i = 0; i < NumFlows; i++) begin : g_flow
      int unsigned waits;
      always_ff @(posedge clk) begin
        waits <= (rst || !push_valid[i] || xfer[i]) ? 32'd0 : waits + 32'(|xfer);
      end
      a_fair: assert property (@(posedge clk) disable iff (rst) waits < 32'(NumFlows));
    end
  end
endmodule

// File: tb/tb_br_flow_mux_select_reg.sv
// tb_br_flow_mux_select_reg: directed checks of fixed, round-robin and 5-flow wrap configurations
module tb_br_flow_mux_select_reg;
  logic clk, rst;
  int checks = 0, errors = 0;
  logic [3:0] a_ready, a_valid;
  logic [3:0][7:0] a_data;
  logic a_pop_ready, a_pop_valid;
  logic [7:0] a_pop_data;
  logic [1:0] a_id;
  logic [2:0] b_ready, b_valid;
  logic [2:0][7:0] b_data;
  logic b_pop_ready, b_pop_valid;
  logic [7:0] b_pop_data;
  logic [1:0] b_id;
  logic [4:0] c_ready, c_valid;
  logic [4:0][7:0] c_data;
  logic c_pop_ready, c_pop_valid;
  logic [7:0] c_pop_data;
  logic [2:0] c_id;
  br_flow_mux_select_reg #(.NumFlows(4), .DataWidth(8), .ArbMode(0)) dut_a (
    .clk(clk), .rst(rst), .push_ready(a_ready), .push_valid(a_valid), .push_data(a_data),
    .pop_ready(a_pop_ready), .pop_valid(a_pop_valid), .pop_data(a_pop_data), .pop_flow_id(a_id));
  br_flow_mux_select_reg #(.NumFlows(3), .DataWidth(8), .ArbMode(1)) dut_b (
    .clk(clk), .rst(rst), .push_ready(b_ready), .push_valid(b_valid), .push_data(b_data),
    .pop_ready(b_pop_ready), .pop_valid(b_pop_valid), .pop_data(b_pop_data), .pop_flow_id(b_id));
  br_flow_mux_select_reg #(.NumFlows(5), .DataWidth(8), .ArbMode(1)) dut_c (
    .clk(clk), .rst(rst), .push_ready(c_ready), .push_valid(c_valid), .push_data(c_data),
    .pop_ready(c_pop_ready), .pop_valid(c_pop_valid), .pop_data(c_pop_data), .pop_flow_id(c_id));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    a_valid = '0; b_valid = '0; c_valid = '0;
    a_pop_ready = 1'b1; b_pop_ready = 1'b1; c_pop_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    a_valid = 4'b1111; b_valid = 3'b111; c_valid = 5'b11111;
    a_data = '0; b_data = '0; c_data = '0;
    a_pop_ready = 1'b1; b_pop_ready = 1'b1; c_pop_ready = 1'b1;
    step();
    step();
    checks++; if (a_ready !== 4'b0) begin errors++; $display("FAIL reset_ready_a got=%b exp=%b", a_ready, 4'b0); end
    checks++; if ({b_ready, c_ready} !== 8'b0) begin errors++; $display("FAIL reset_ready_bc got=%b exp=%b", {b_ready, c_ready}, 8'b0); end
    checks++; if ({a_pop_valid, b_pop_valid, c_pop_valid} !== 3'b0) begin errors++; $display("FAIL reset_valid got=%b exp=000", {a_pop_valid, b_pop_valid, c_pop_valid}); end
    checks++; if ({a_pop_data, a_id} !== 10'h0) begin errors++; $display("FAIL reset_data_id got=%h exp=0", {a_pop_data, a_id}); end
    a_valid = '0; b_valid = '0; c_valid = '0;
    step();
    rst = 1'b0;
  endtask
  task automatic test_fixed();
    do_reset();
    a_data = {8'h44, 8'h22, 8'h11, 8'h00};
    a_valid = 4'b0110;
    #1;
    checks++; if (a_ready !== 4'b0010) begin errors++; $display("FAIL fixed_ready_empty got=%b exp=%b", a_ready, 4'b0010); end
    step();
    checks++; if ({a_pop_valid, a_pop_data, a_id} !== {1'b1, 8'h11, 2'd1}) begin errors++; $display("FAIL fixed_first got=%b/%h/%0d exp=1/11/1", a_pop_valid, a_pop_data, a_id); end
    for (int n = 0; n < 3; n++) begin
      step();
      checks++; if ({a_ready, a_pop_valid, a_id} !== {4'b0010, 1'b1, 2'd1}) begin errors++; $display("FAIL fixed_starve got=%b/%b/%0d exp=0010/1/1", a_ready, a_pop_valid, a_id); end
    end
    a_valid = 4'b0100;
    step();
    checks++; if ({a_pop_valid, a_pop_data, a_id} !== {1'b1, 8'h22, 2'd2}) begin errors++; $display("FAIL fixed_flow2 got=%b/%h/%0d exp=1/22/2", a_pop_valid, a_pop_data, a_id); end
    a_valid = 4'b0000;
    step();
    checks++; if ({a_pop_valid, a_pop_data, a_id} !== {1'b0, 8'h22, 2'd2}) begin errors++; $display("FAIL fixed_drain got=%b/%h/%0d exp=0/22/2", a_pop_valid, a_pop_data, a_id); end
  endtask
  task automatic test_backpressure();
    do_reset();
    a_data = {8'h77, 8'h00, 8'h00, 8'h5A};
    a_valid = 4'b0001;
    step();
    checks++; if ({a_pop_valid, a_pop_data, a_id} !== {1'b1, 8'h5A, 2'd0}) begin errors++; $display("FAIL bp_load got=%b/%h/%0d exp=1/5a/0", a_pop_valid, a_pop_data, a_id); end
    a_pop_ready = 1'b0;
    a_valid = 4'b1000;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (a_ready !== 4'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0000", a_ready); end
      step();
      checks++; if ({a_pop_valid, a_pop_data, a_id} !== {1'b1, 8'h5A, 2'd0}) begin errors++; $display("FAIL bp_hold got=%b/%h/%0d exp=1/5a/0", a_pop_valid, a_pop_data, a_id); end
    end
    a_pop_ready = 1'b1;
    #1;
    checks++; if (a_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got=%b exp=1000", a_ready); end
    step();
    checks++; if ({a_pop_valid, a_pop_data, a_id} !== {1'b1, 8'h77, 2'd3}) begin errors++; $display("FAIL bp_next got=%b/%h/%0d exp=1/77/3", a_pop_valid, a_pop_data, a_id); end
  endtask
  task automatic test_rr();
    logic [1:0] exp_id [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    do_reset();
    b_data = {8'h12, 8'h11, 8'h10};
    b_valid = 3'b111;
    #1;
    checks++; if (b_ready !== 3'b001) begin errors++; $display("FAIL rr_first_ready got=%b exp=001", b_ready); end
    for (int n = 0; n < 6; n++) begin
      step();
      checks++; if ({b_pop_valid, b_id, b_pop_data} !== {1'b1, exp_id[n], 8'h10 + 8'(exp_id[n])}) begin errors++; $display("FAIL rr_seq[%0d] got=%b/%0d/%h exp=1/%0d", n, b_pop_valid, b_id, b_pop_data, exp_id[n]); end
    end
  endtask
  task automatic test_rr_stall();
    do_reset();
    b_data = {8'h12, 8'h11, 8'h10};
    b_valid = 3'b010;
    step();
    checks++; if ({b_pop_valid, b_id} !== {1'b1, 2'd1}) begin errors++; $display("FAIL stall_load got=%b/%0d exp=1/1", b_pop_valid, b_id); end
    b_pop_ready = 1'b0;
    b_valid = 3'b101;
    for (int n = 0; n < 2; n++) begin
      #1;
      checks++; if (b_ready !== 3'b000) begin errors++; $display("FAIL stall_ready got=%b exp=000", b_ready); end
      step();
      checks++; if ({b_pop_valid, b_id} !== {1'b1, 2'd1}) begin errors++; $display("FAIL stall_hold got=%b/%0d exp=1/1", b_pop_valid, b_id); end
    end
    b_pop_ready = 1'b1;
    #1;
    checks++; if (b_ready !== 3'b100) begin errors++; $display("FAIL stall_release_ready got=%b exp=100", b_ready); end
    step();
    checks++; if ({b_pop_valid, b_id, b_pop_data} !== {1'b1, 2'd2, 8'h12}) begin errors++; $display("FAIL stall_flow2 got=%b/%0d/%h exp=1/2/12", b_pop_valid, b_id, b_pop_data); end
    #1;
    checks++; if (b_ready !== 3'b001) begin errors++; $display("FAIL stall_wrap_ready got=%b exp=001", b_ready); end
    step();
    checks++; if ({b_pop_valid, b_id} !== {1'b1, 2'd0}) begin errors++; $display("FAIL stall_flow0 got=%b/%0d exp=1/0", b_pop_valid, b_id); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    b_data = {8'h12, 8'h11, 8'h10};
    b_valid = 3'b111;
    step();
    step();
    checks++; if ({b_pop_valid, b_id} !== {1'b1, 2'd1}) begin errors++; $display("FAIL mid_pre got=%b/%0d exp=1/1", b_pop_valid, b_id); end
    rst = 1'b1;
    #1;
    checks++; if (b_ready !== 3'b000) begin errors++; $display("FAIL mid_ready_in_reset got=%b exp=000", b_ready); end
    step();
    checks++; if (b_pop_valid !== 1'b0) begin errors++; $display("FAIL mid_dropped got=%b exp=0", b_pop_valid); end
    rst = 1'b0;
    #1;
    checks++; if (b_ready !== 3'b001) begin errors++; $display("FAIL mid_ptr_ready got=%b exp=001", b_ready); end
    step();
    checks++; if ({b_pop_valid, b_id, b_pop_data} !== {1'b1, 2'd0, 8'h10}) begin errors++; $display("FAIL mid_first got=%b/%0d/%h exp=1/0/10", b_pop_valid, b_id, b_pop_data); end
  endtask
  task automatic test_wrap();
    logic [2:0] exp_id [4] = '{3'd0, 3'd4, 3'd0, 3'd4};
    do_reset();
    c_data = {8'hA4, 8'h00, 8'h00, 8'h00, 8'hA0};
    c_valid = 5'b10001;
    for (int n = 0; n < 4; n++) begin
      step();
      checks++; if ({c_pop_valid, c_id, c_pop_data} !== {1'b1, exp_id[n], 8'hA0 + 8'(exp_id[n])}) begin errors++; $display("FAIL wrap[%0d] got=%b/%0d/%h exp=1/%0d", n, c_pop_valid, c_id, c_pop_data, exp_id[n]); end
    end
  endtask
  initial begin
    clk = 1'b0;
    test_reset();
    test_fixed();
    test_backpressure();
    test_rr();
    test_rr_stall();
    test_reset_mid();
    test_wrap();
    do_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
